incdec_counter_arbiter: RTL
===========================

// Module: incdec_counter_arbiter
// PURPOSE
//  Shares one incdec_counter instance among NREQ requesters that need to
//  increment or decrement it, plus one load port.
//  Picks one request per cycle (load first, then round-robin) and drives the
//  counter's enable/load/inc/dec/i0 controls from registers.
//  Keeps a shadow copy of the count so it can guard against over/underflow
//  without waiting for the counter to update.
//  Sits between producer/consumer engines and the shared counter (credit pools, occupancy).
// PARAMETERS
//  width   32  counter width; must match the incdec_counter instance
//  countby 1   step; must match the incdec_counter instance
//  nreq    4   number of inc/dec requesters (2..16)
// PORTS
//  clk         in   1        system clock, rising edge
//  reset       in   1        asynchronous, active-low reset
//  ld_req      in   1        load request, level, highest priority
//  ld_val      in   width    value to load
//  ld_ack      out  1        1-cycle pulse: load issued
//  req         in   nreq     per-requester request, held until acked
//  op          in   nreq     per-requester op: 1=inc, 0=dec; stable while req=1
//  ack         out  nreq     1-cycle pulse: this requester's op issued (one-hot or zero)
//  cnt_enable  out  1        to counter enable
//  cnt_load    out  1        to counter load
//  cnt_inc     out  1        to counter inc
//  cnt_dec     out  1        to counter dec
//  cnt_i0      out  width    to counter i0
//  count       out  width    shadow count; equals counter o0 one cycle after issue
//  ovf_block   out  1        1-cycle pulse: a request was skipped by the sat guard
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0, shadow=0, rr pointer=0.
//  - All decisions are made on the rising clk edge; outputs are registered.
//    An op issued at edge t is applied by the counter at edge t+1.
//  - Eligibility: req[i]=1 AND ack[i]=0. The ack[i]=0 term stops a request
//    from being granted twice; a requester is granted at most every 2nd cycle.
//  - Load: if ld_req=1 and ld_ack=0: cnt_enable=cnt_load=1, cnt_i0=ld_val,
//    ld_ack=1, shadow<=ld_val.
//    No ack[] is given that cycle and the rr pointer does not move.
//  - Otherwise: scan eligible requesters from ptr, ptr+1, ... wrapping mod nreq.
//    Grant the first one that passes the sat guard (see CONFIGURATION).
//    Grant k: ack[k]=1, cnt_enable=1, cnt_inc=op[k], cnt_dec=~op[k],
//    shadow<=shadow+/-countby (width bits), ptr<=(k+1) mod nreq.
//  - Nothing granted: cnt_enable=cnt_inc=cnt_dec=cnt_load=0; the counter holds.
//  - Never asserts cnt_inc and cnt_dec together. cnt_i0 holds its last value when not loading.
//  - ld_ack and any ack bit are never high in the same cycle.
//  - Shadow arithmetic is modulo 2^width; count = shadow.
//  - Reset mid-operation: control outputs drop at once (async).
//    Any op issued but not yet applied is discarded along with the counter reset.
// CONFIGURATION
//  INCDEC_ARB_SATURATE_EN defined:
//  - dec is eligible only if shadow >= countby.
//  - inc is eligible only if shadow <= 2^width-1-countby.
//  - Skipped requests keep req pending and pulse ovf_block in the cycle after the skip.
//  - The scan carries on to the next eligible requester.
//  Not defined: no guard, the count wraps, ovf_block is tied to 0.
// TESTING (width=8, countby=1, nreq=4)
//  1. Release reset, no req -> all outputs 0 for 5 cycles, count=0.
//  2. req=4'b1111, op=4'b1111 held -> ack order 0001,0010,0100,1000,0001;
//     count reaches 4 after 4 grants; no cycle with two grants.
//  3. ld_req with ld_val=8'hA5 while req=4'b0011 -> ld_ack first, cnt_load=1, cnt_i0=A5;
//     next cycle ack=0001 with count=A5+/-1.
//  4. SAT_EN, count=0, req[2]=1 op=dec, req[3]=1 op=inc -> req2 skipped,
//     ovf_block pulses, ack=1000, count=1; next ack=0100, count=0.
//  5. No SAT_EN, count=0, single dec -> count=8'hFF, ovf_block=0;
//     load FF then inc -> count=00.
//  6. Drop reset while cnt_enable=1 -> outputs 0 in the same cycle; after release, count=0.

Source files
------------

// File: rtl/incdec_counter_arbiter.sv
// incdec_counter_arbiter: load-first, round-robin sharing of one incdec_counter with a shadow count.
// Define INCDEC_ARB_SATURATE_EN to skip requests that would over/underflow the shadow count.
module incdec_counter_arbiter #(
   parameter int width   = 32,
   parameter int countby = 1,
   parameter int nreq    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ld_req,
   input  logic [width-1:0]  ld_val,
   output logic              ld_ack,
   input  logic [nreq-1:0]   req,
   input  logic [nreq-1:0]   op,
   output logic [nreq-1:0]   ack,
   output logic              cnt_enable,
   output logic              cnt_load,
   output logic              cnt_inc,
   output logic              cnt_dec,
   output logic [width-1:0]  cnt_i0,
   output logic [width-1:0]  count,
   output logic              ovf_block
);
   localparam int pw = $clog2(nreq);
   localparam logic [width-1:0] step = width'(countby);
   logic [pw-1:0]   ptr, k, ix;
   logic [nreq-1:0] pend, ok;
   logic            found, skip, ld_go, gnt;
   assign pend  = req & ~ack;
   assign ld_go = ld_req & ~ld_ack;
   assign gnt   = found & ~ld_go;
`ifdef INCDEC_ARB_SATURATE_EN
   for (genvar i = 0; i < nreq; i++) begin : g_ok
      assign ok[i] = op[i] ? (count <= ~step) : (count >= step);
   end
`else
   assign ok = '1;
`endif
   // Scan from ptr; guarded-out requests seen before the winner count as skipped.
   always_comb begin
      found = 1'b0;
      skip  = 1'b0;
      k     = '0;
      ix    = '0;
      for (int j = 0; j < nreq; j++) begin
         ix = pw'((int'(ptr) + j) % nreq);
         if (!found && pend[ix]) begin
            if (ok[ix]) begin
               found = 1'b1;
               k     = ix;
            end else
               skip = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ld_ack     <= 1'b0;
         ack        <= '0;
         cnt_enable <= 1'b0;
         cnt_load   <= 1'b0;
         cnt_inc    <= 1'b0;
         cnt_dec    <= 1'b0;
         cnt_i0     <= '0;
         count      <= '0;
         ovf_block  <= 1'b0;
         ptr        <= '0;
      end else begin
         ld_ack     <= ld_go;
         cnt_load   <= ld_go;
         cnt_enable <= ld_go | found;
         cnt_inc    <= gnt & op[k];
         cnt_dec    <= gnt & ~op[k];
         ack        <= gnt ? nreq'(1) << k : '0;
         ovf_block  <= ~ld_go & skip;
         if (ld_go) begin
            cnt_i0 <= ld_val;
            count  <= ld_val;
         end else if (gnt) begin
            count <= op[k] ? count + step : count - step;
            ptr   <= (int'(k) == nreq - 1) ? '0 : k + 1'b1;
         end
      end
endmodule
